// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: default field widths, channel opcodes and
// the arbiter FSM encoding.
package tl_ul_pkg;

    localparam int unsigned TL_ADDR_WIDTH_DEF   = 64;
    localparam int unsigned TL_DATA_WIDTH_DEF   = 64;
    localparam int unsigned TL_SOURCE_WIDTH_DEF = 3;
    localparam int unsigned TL_SINK_WIDTH_DEF   = 3;
    localparam int unsigned TL_OPCODE_WIDTH_DEF = 3;
    localparam int unsigned TL_PARAM_WIDTH_DEF  = 3;
    localparam int unsigned TL_SIZE_WIDTH_DEF   = 8;
    localparam int unsigned NUM_MASTERS_DEF     = 2;
    localparam int unsigned TXN_COUNT_WIDTH     = 16;

    localparam logic [TL_OPCODE_WIDTH_DEF-1:0] PUT_FULL_DATA_A    = 3'd0;
    localparam logic [TL_OPCODE_WIDTH_DEF-1:0] PUT_PARTIAL_DATA_A = 3'd1;
    localparam logic [TL_OPCODE_WIDTH_DEF-1:0] GET_A              = 3'd4;
    localparam logic [TL_OPCODE_WIDTH_DEF-1:0] ACCESS_ACK_D       = 3'd0;
    localparam logic [TL_OPCODE_WIDTH_DEF-1:0] ACCESS_ACK_DATA_D  = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQUEST  = 2'd1,
        ST_RESPONSE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/tl_ul_rr_picker.sv
// Round-robin pick: first asserted request at or after rr_ptr, wrapping.
module tl_ul_rr_picker #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IW = $clog2(N);

    logic [31:0] slot;
    logic        found;

    always_comb begin
        any   = |req;
        idx   = '0;
        slot  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            slot = (32'(rr_ptr) + k) % N;
            if (!found && req[slot[IW-1:0]]) begin
                found = 1'b1;
                idx   = slot[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/tilelink_ul_arbiter.sv
// N-to-1 TileLink-UL arbiter with one outstanding transaction, round-robin
// grant, and D-channel routing back to the latched owner.
module tilelink_ul_arbiter
    import tl_ul_pkg::*;
#(
    parameter int unsigned TL_ADDR_WIDTH   = TL_ADDR_WIDTH_DEF,
    parameter int unsigned TL_DATA_WIDTH   = TL_DATA_WIDTH_DEF,
    parameter int unsigned TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
    parameter int unsigned TL_SOURCE_WIDTH = TL_SOURCE_WIDTH_DEF,
    parameter int unsigned TL_SINK_WIDTH   = TL_SINK_WIDTH_DEF,
    parameter int unsigned TL_OPCODE_WIDTH = TL_OPCODE_WIDTH_DEF,
    parameter int unsigned TL_PARAM_WIDTH  = TL_PARAM_WIDTH_DEF,
    parameter int unsigned TL_SIZE_WIDTH   = TL_SIZE_WIDTH_DEF,
    parameter int unsigned NUM_MASTERS     = NUM_MASTERS_DEF
) (
    input  logic                                     clk,
    input  logic                                     rst,

    input  logic [NUM_MASTERS-1:0]                   m_a_valid,
    output logic [NUM_MASTERS-1:0]                   m_a_ready,
    input  logic [NUM_MASTERS*TL_OPCODE_WIDTH-1:0]   m_a_opcode,
    input  logic [NUM_MASTERS*TL_PARAM_WIDTH-1:0]    m_a_param,
    input  logic [NUM_MASTERS*TL_ADDR_WIDTH-1:0]     m_a_address,
    input  logic [NUM_MASTERS*TL_SIZE_WIDTH-1:0]     m_a_size,
    input  logic [NUM_MASTERS*TL_STRB_WIDTH-1:0]     m_a_mask,
    input  logic [NUM_MASTERS*TL_DATA_WIDTH-1:0]     m_a_data,
    input  logic [NUM_MASTERS*TL_SOURCE_WIDTH-1:0]   m_a_source,

    output logic [NUM_MASTERS-1:0]                   m_d_valid,
    input  logic [NUM_MASTERS-1:0]                   m_d_ready,
    output logic [TL_OPCODE_WIDTH-1:0]               m_d_opcode,
    output logic [TL_PARAM_WIDTH-1:0]                m_d_param,
    output logic [TL_SIZE_WIDTH-1:0]                 m_d_size,
    output logic [TL_SINK_WIDTH-1:0]                 m_d_sink,
    output logic [TL_SOURCE_WIDTH-1:0]               m_d_source,
    output logic [TL_DATA_WIDTH-1:0]                 m_d_data,
    output logic                                     m_d_error,

    output logic                                     s_a_valid,
    input  logic                                     s_a_ready,
    output logic [TL_OPCODE_WIDTH-1:0]               s_a_opcode,
    output logic [TL_PARAM_WIDTH-1:0]                s_a_param,
    output logic [TL_ADDR_WIDTH-1:0]                 s_a_address,
    output logic [TL_SIZE_WIDTH-1:0]                 s_a_size,
    output logic [TL_STRB_WIDTH-1:0]                 s_a_mask,
    output logic [TL_DATA_WIDTH-1:0]                 s_a_data,
    output logic [TL_SOURCE_WIDTH-1:0]               s_a_source,

    input  logic                                     s_d_valid,
    output logic                                     s_d_ready,
    input  logic [TL_OPCODE_WIDTH-1:0]               s_d_opcode,
    input  logic [TL_PARAM_WIDTH-1:0]                s_d_param,
    input  logic [TL_SIZE_WIDTH-1:0]                 s_d_size,
    input  logic [TL_SINK_WIDTH-1:0]                 s_d_sink,
    input  logic [TL_SOURCE_WIDTH-1:0]               s_d_source,
    input  logic [TL_DATA_WIDTH-1:0]                 s_d_data,
    input  logic                                     s_d_error,

    output logic [$clog2(NUM_MASTERS)-1:0]           grant_idx,
    output logic                                     busy,
    output logic [TXN_COUNT_WIDTH-1:0]               txn_count
);

    localparam int unsigned IW = $clog2(NUM_MASTERS);

    arb_state_t                 state, state_d;
    logic [IW-1:0]              rr_ptr, rr_ptr_d;
    logic [IW-1:0]              grant_d;
    logic [TXN_COUNT_WIDTH-1:0] txn_d;
    logic                       pick_any;
    logic [IW-1:0]              pick_idx;
    logic [31:0]                gsel;

    tl_ul_rr_picker #(
        .N(NUM_MASTERS)
    ) u_picker (
        .req    (m_a_valid),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    // State register; busy tracks the registered state directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            txn_count <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            grant_idx <= grant_d;
            txn_count <= txn_d;
            busy      <= (state_d != ST_IDLE);
        end
    end

    // Next-state: the owner is latched in IDLE and held until the D beat.
    always_comb begin
        state_d  = state;
        rr_ptr_d = rr_ptr;
        grant_d  = grant_idx;
        txn_d    = txn_count;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (s_a_valid && s_a_ready) begin
                    state_d = ST_RESPONSE;
                end
            end
            ST_RESPONSE: begin
                if (s_d_valid && s_d_ready) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_idx == IW'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
                    txn_d    = txn_count + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gsel = 32'(grant_idx);

    // Handshake steering; A fields always track the owner, valid gates use.
    always_comb begin
        s_a_opcode  = m_a_opcode [gsel*TL_OPCODE_WIDTH +: TL_OPCODE_WIDTH];
        s_a_param   = m_a_param  [gsel*TL_PARAM_WIDTH  +: TL_PARAM_WIDTH];
        s_a_address = m_a_address[gsel*TL_ADDR_WIDTH   +: TL_ADDR_WIDTH];
        s_a_size    = m_a_size   [gsel*TL_SIZE_WIDTH   +: TL_SIZE_WIDTH];
        s_a_mask    = m_a_mask   [gsel*TL_STRB_WIDTH   +: TL_STRB_WIDTH];
        s_a_data    = m_a_data   [gsel*TL_DATA_WIDTH   +: TL_DATA_WIDTH];
        s_a_source  = m_a_source [gsel*TL_SOURCE_WIDTH +: TL_SOURCE_WIDTH];
        s_a_valid   = 1'b0;
        m_a_ready   = '0;
        s_d_ready   = 1'b0;
        m_d_valid   = '0;
        if (state == ST_REQUEST) begin
            s_a_valid            = m_a_valid[grant_idx];
            m_a_ready[grant_idx] = s_a_ready;
        end
        if (state == ST_RESPONSE) begin
            m_d_valid[grant_idx] = s_d_valid;
            s_d_ready            = m_d_ready[grant_idx];
        end
    end

    assign m_d_opcode = s_d_opcode;
    assign m_d_param  = s_d_param;
    assign m_d_size   = s_d_size;
    assign m_d_sink   = s_d_sink;
    assign m_d_source = s_d_source;
    assign m_d_data   = s_d_data;
    assign m_d_error  = s_d_error;

endmodule

// File: tb/tb_tilelink_ul_arbiter.sv
// Directed and randomized checks of tilelink_ul_arbiter against a
// transaction-level round-robin model.
module tb_tilelink_ul_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0]    m_a_valid, m_a_ready;
    logic [N*3-1:0]  m_a_opcode, m_a_param, m_a_source;
    logic [N*64-1:0] m_a_address, m_a_data;
    logic [N*8-1:0]  m_a_size, m_a_mask;
    logic [N-1:0]    m_d_valid, m_d_ready;
    logic [2:0]      m_d_opcode, m_d_param, m_d_sink, m_d_source;
    logic [7:0]      m_d_size;
    logic [63:0]     m_d_data;
    logic            m_d_error;
    logic            s_a_valid, s_a_ready;
    logic [2:0]      s_a_opcode, s_a_param, s_a_source;
    logic [63:0]     s_a_address, s_a_data;
    logic [7:0]      s_a_size, s_a_mask;
    logic            s_d_valid, s_d_ready;
    logic [2:0]      s_d_opcode, s_d_param, s_d_sink, s_d_source;
    logic [7:0]      s_d_size;
    logic [63:0]     s_d_data;
    logic            s_d_error;
    logic [1:0]      grant_idx;
    logic            busy;
    logic [15:0]     txn_count;

    tilelink_ul_arbiter #(.NUM_MASTERS(N)) dut (
        .clk(clk), .rst(rst),
        .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_opcode(m_a_opcode),
        .m_a_param(m_a_param), .m_a_address(m_a_address), .m_a_size(m_a_size),
        .m_a_mask(m_a_mask), .m_a_data(m_a_data), .m_a_source(m_a_source),
        .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_opcode(m_d_opcode),
        .m_d_param(m_d_param), .m_d_size(m_d_size), .m_d_sink(m_d_sink),
        .m_d_source(m_d_source), .m_d_data(m_d_data), .m_d_error(m_d_error),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_address(s_a_address), .s_a_size(s_a_size),
        .s_a_mask(s_a_mask), .s_a_data(s_a_data), .s_a_source(s_a_source),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_sink(s_d_sink),
        .s_d_source(s_d_source), .s_d_data(s_d_data), .s_d_error(s_d_error),
        .grant_idx(grant_idx), .busy(busy), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    // Reference model: per-master request contents and pending set.
    logic [2:0]  r_opc [N];
    logic [2:0]  r_par [N];
    logic [2:0]  r_src [N];
    logic [63:0] r_addr[N];
    logic [63:0] r_data[N];
    logic [7:0]  r_size[N];
    logic [7:0]  r_mask[N];
    logic [N-1:0] pending;
    logic [N-1:0] junk;
    int           ptr;
    logic [15:0]  exp_txn;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            m_a_opcode [i*3 +: 3]   = r_opc[i];
            m_a_param  [i*3 +: 3]   = r_par[i];
            m_a_source [i*3 +: 3]   = r_src[i];
            m_a_address[i*64 +: 64] = r_addr[i];
            m_a_data   [i*64 +: 64] = r_data[i];
            m_a_size   [i*8 +: 8]   = r_size[i];
            m_a_mask   [i*8 +: 8]   = r_mask[i];
        end
        m_a_valid = pending | junk;
    endtask

    task automatic set_req(input int i, input logic [2:0] opc, input logic [63:0] addr,
                           input logic [2:0] src, input logic [63:0] data);
        r_opc[i]  = opc;
        r_addr[i] = addr;
        r_src[i]  = src;
        r_data[i] = data;
        r_par[i]  = 3'($urandom);
        r_size[i] = 8'($urandom_range(0, 3));
        r_mask[i] = 8'($urandom);
        pending[i] = 1'b1;
        drive_masters();
    endtask

    task automatic rand_req(input int i);
        logic [2:0] opc;
        case ($urandom_range(0, 2))
            0:       opc = 3'd0;
            1:       opc = 3'd1;
            default: opc = 3'd4;
        endcase
        set_req(i, opc, {$urandom, $urandom}, 3'($urandom), {$urandom, $urandom});
    endtask

    // Winner = pending master with the smallest forward distance from ptr.
    function automatic int pick_model();
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (pending[i] && ((i - ptr + N) % N) < bestd) begin
                bestd = (i - ptr + N) % N;
                best  = i;
            end
        end
        return best;
    endfunction

    // One full transaction owned by master exp; entered during the IDLE cycle.
    task automatic serve(input int exp, input int a_wait, input int d_wait,
                         input logic [63:0] dd, input logic [2:0] dopc, input bit add_rand);
        logic [N-1:0] oh;
        oh = '0;
        oh[exp] = 1'b1;
        for (int k = 0; k <= a_wait; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                junk[i] = !pending[i] && 1'($urandom);
                if (!pending[i]) r_addr[i] = {$urandom, $urandom};
            end
            drive_masters();
            s_a_ready = (k == a_wait);
            #1;
            check("a_valid", 64'(s_a_valid), 64'd1);
            check("a_grant", 64'(grant_idx), 64'(exp));
            check("a_address", s_a_address, r_addr[exp]);
            check("a_source", 64'(s_a_source), 64'(r_src[exp]));
            check("a_ready", 64'(m_a_ready), s_a_ready ? 64'(oh) : 64'd0);
            check("d_held_in_req", 64'({m_d_valid, s_d_ready}), 64'd0);
            check("busy_req", 64'(busy), 64'd1);
            if (k == a_wait) begin
                check("a_opcode", 64'(s_a_opcode), 64'(r_opc[exp]));
                check("a_data", s_a_data, r_data[exp]);
                check("a_mask_size_param", 64'({s_a_mask, s_a_size, s_a_param}),
                      64'({r_mask[exp], r_size[exp], r_par[exp]}));
            end
        end
        @(negedge clk);
        s_a_ready    = 1'b0;
        pending[exp] = 1'b0;
        junk         = '0;
        drive_masters();
        if (add_rand)
            for (int i = 0; i < N; i++)
                if (!pending[i] && $urandom_range(0, 1) == 1) rand_req(i);
        for (int k = 0; k <= d_wait; k++) begin
            if (k > 0) @(negedge clk);
            s_d_valid  = (k == d_wait);
            s_d_data   = (k == d_wait) ? dd : {$urandom, $urandom};
            s_d_opcode = dopc;
            s_d_source = r_src[exp];
            s_d_size   = r_size[exp];
            s_d_param  = 3'($urandom);
            s_d_sink   = 3'($urandom);
            s_d_error  = 1'($urandom);
            #1;
            check("d_route", 64'(m_d_valid), s_d_valid ? 64'(oh) : 64'd0);
            check("d_ready", 64'(s_d_ready), 64'd1);
            check("a_quiet_in_resp", 64'({s_a_valid, m_a_ready}), 64'd0);
            if (k == d_wait) begin
                check("d_data", m_d_data, dd);
                check("d_opcode", 64'(m_d_opcode), 64'(dopc));
                check("d_source", 64'(m_d_source), 64'(r_src[exp]));
                check("d_error", 64'(m_d_error), 64'(s_d_error));
            end
        end
        @(negedge clk);
        s_d_valid = 1'b0;
        ptr       = (exp + 1) % N;
        exp_txn   = exp_txn + 16'd1;
        #1;
        check("txn_count", 64'(txn_count), 64'(exp_txn));
        check("busy_idle", 64'(busy), 64'd0);
        check("d_idle", 64'(m_d_valid), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_grant"}, 64'(grant_idx), 64'd0);
        check({tag, "_txn"}, 64'(txn_count), 64'd0);
        check({tag, "_handshakes"},
              64'({s_a_valid, s_d_ready, m_a_ready, m_d_valid}), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        pending   = '0;
        junk      = '0;
        s_d_valid = 1'b0;
        s_a_ready = 1'b0;
        m_d_ready = '1;
        ptr       = 0;
        exp_txn   = 16'd0;
        drive_masters();
        #1;
        check_reset_outputs("reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[4];
        order = '{0, 1, 0, 1};
        for (int i = 0; i < N; i++) begin
            r_opc[i] = '0; r_par[i] = '0; r_src[i] = '0; r_addr[i] = '0;
            r_data[i] = '0; r_size[i] = '0; r_mask[i] = '0;
        end
        s_d_opcode = '0; s_d_param = '0; s_d_size = '0; s_d_sink = '0;
        s_d_source = '0; s_d_data = '0; s_d_error = 1'b0;
        rst = 1'b0;
        do_reset();
        @(negedge clk);
        #1;
        check_reset_outputs("reset_hold");
        rst = 1'b1;

        // Single master Get answered with AccessAckData.
        set_req(0, 3'd4, 64'h40, 3'd1, 64'd0);
        serve(0, 0, 1, 64'hDEADBEEF, 3'd1, 1'b0);
        check("single_txn1", 64'(txn_count), 64'd1);

        // Two masters contending continuously from reset.
        do_reset();
        set_req(0, 3'd4, 64'h100, 3'd2, 64'd0);
        set_req(1, 3'd0, 64'h200, 3'd3, 64'h1234);
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 4; r++) begin
            serve(order[r], $urandom_range(0, 2), $urandom_range(0, 2),
                  {$urandom, $urandom}, 3'd1, 1'b0);
            if (r < 3) rand_req(order[r]);
        end
        check("contend_txn4", 64'(txn_count), 64'd4);

        // Slave backpressure for five cycles while m1 waits.
        do_reset();
        set_req(0, 3'd1, 64'hA0, 3'd5, 64'h55AA);
        set_req(1, 3'd4, 64'hB0, 3'd6, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        serve(0, 5, 0, 64'h77, 3'd0, 1'b0);
        serve(1, 0, 2, 64'h88, 3'd1, 1'b0);

        // D beat offered while idle must be held off.
        @(negedge clk);
        s_d_valid = 1'b1;
        s_d_data  = 64'hBAD;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("spurious_d_ready", 64'(s_d_ready), 64'd0);
            check("spurious_d_valid", 64'(m_d_valid), 64'd0);
            @(negedge clk);
        end
        set_req(1, 3'd4, 64'hC0, 3'd0, 64'd0);
        serve(1, 1, 0, 64'h99, 3'd1, 1'b0);

        // Reset in the middle of a response.
        set_req(0, 3'd4, 64'hD0, 3'd1, 64'd0);
        serve(0, 0, 0, 64'h11, 3'd1, 1'b0);
        set_req(1, 3'd4, 64'hE0, 3'd2, 64'd0);
        @(negedge clk);
        s_a_ready = 1'b1;
        #1;
        check("midrst_grant", 64'(grant_idx), 64'd1);
        @(negedge clk);
        s_a_ready = 1'b0;
        pending   = '0;
        drive_masters();
        m_d_ready = '0;
        s_d_valid = 1'b1;
        #1;
        check("midrst_in_resp", 64'({busy, m_d_valid}), 64'({1'b1, 3'b010}));
        @(negedge clk);
        rst     = 1'b0;
        ptr     = 0;
        exp_txn = 16'd0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst       = 1'b1;
        m_d_ready = '1;
        #1;
        check("midrst_no_dbeat", 64'(m_d_valid), 64'd0);
        set_req(0, 3'd0, 64'hF0, 3'd3, 64'hFACE);
        set_req(1, 3'd0, 64'hF8, 3'd4, 64'hCAFE);
        serve(0, 0, 0, 64'h21, 3'd0, 1'b0);
        serve(1, 0, 0, 64'h22, 3'd0, 1'b0);

        // Transaction counter wrap.
        @(negedge clk);
        force dut.txn_count = 16'hFFFF;
        @(negedge clk);
        release dut.txn_count;
        #1;
        check("wrap_preload", 64'(txn_count), 64'hFFFF);
        exp_txn = 16'hFFFF;
        set_req(2, 3'd4, 64'h300, 3'd7, 64'd0);
        serve(2, 0, 0, 64'h33, 3'd1, 1'b0);
        check("wrap_zero", 64'(txn_count), 64'd0);

        // Randomized traffic against the round-robin model.
        for (int t = 0; t < 60; t++) begin
            if (pending == '0) rand_req($urandom_range(0, N - 1));
            for (int i = 0; i < N; i++)
                if (!pending[i] && $urandom_range(0, 3) == 0) rand_req(i);
            serve(pick_model(), $urandom_range(0, 3), $urandom_range(0, 3),
                  {$urandom, $urandom}, 3'($urandom_range(0, 1)), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tilelink_ul_arbiter.md
TILELINK_UL_ARBITER -- requirements
Module: tilelink_ul_arbiter

Interface
REQ-001 SHALL have parameter TL_ADDR_WIDTH, default 64, meaning address width.
REQ-002 SHALL have parameter TL_DATA_WIDTH, default 64, meaning data width.
REQ-003 SHALL have parameter TL_STRB_WIDTH, default TL_DATA_WIDTH/8, meaning mask width.
REQ-004 SHALL have parameter TL_SOURCE_WIDTH / TL_SINK_WIDTH / TL_OPCODE_WIDTH / TL_PARAM_WIDTH, default 3 each, meaning field widths.
REQ-005 SHALL have parameter TL_SIZE_WIDTH, default 8, meaning size field width.
REQ-006 SHALL have parameter NUM_MASTERS, default 2, range 2..8, meaning number of requesting masters.
REQ-007 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, meaning reset; asynchronous, active-low.
REQ-009 SHALL have ports m_a_valid / m_a_ready, input / output, NUM_MASTERS, meaning per-master A-channel handshake.
REQ-010 SHALL have ports m_a_opcode, m_a_param, m_a_address, m_a_size, m_a_mask, m_a_data, m_a_source, input, NUM_MASTERS x field width (packed, master i at slice i), meaning per-master A fields.
REQ-011 SHALL have ports m_d_valid / m_d_ready, output / input, NUM_MASTERS, meaning per-master D-channel handshake.
REQ-012 SHALL have ports m_d_opcode, m_d_param, m_d_size, m_d_sink, m_d_source, m_d_data, m_d_error, output, field width, meaning D fields broadcast to all masters.
REQ-013 SHALL have ports s_a_valid, s_a_ready, s_a_* fields, output/input/output, meaning slave-side A channel.
REQ-014 SHALL have ports s_d_valid, s_d_ready, s_d_* fields, input/output/input, meaning slave-side D channel.
REQ-015 SHALL have ports grant_idx (output, clog2(NUM_MASTERS)), busy (output, 1), and txn_count (output, 16), meaning current owner, not-IDLE, and completed transactions.

Function
REQ-016 SHALL implement the FSM IDLE -> REQUEST -> RESPONSE -> IDLE, encoded 2'd0 / 2'd1 / 2'd2.
REQ-017 In IDLE, if any m_a_valid is set, the block SHALL register grant_idx as the first asserted index at or after rr_ptr, wrapping modulo NUM_MASTERS, and enter REQUEST on the next edge.
REQ-018 In REQUEST, s_a_valid and s_a_* SHALL combinationally mirror master grant_idx.
REQ-019 In REQUEST, m_a_ready[grant_idx] SHALL equal s_a_ready; every other m_a_ready SHALL be 0.
REQ-020 On s_a_valid && s_a_ready, the FSM SHALL enter RESPONSE.
REQ-021 In RESPONSE, m_d_valid[grant_idx] SHALL equal s_d_valid, s_d_ready SHALL equal m_d_ready[grant_idx], and other m_d_valid SHALL be 0.
REQ-022 On the D handshake, the FSM SHALL return to IDLE, set rr_ptr to (grant_idx+1) mod NUM_MASTERS, and increment txn_count, wrapping at 16'hFFFF -> 0.
REQ-023 D routing SHALL use the latched grant_idx only; a_source/d_source SHALL pass through unmodified.
REQ-024 Outside REQUEST, s_a_valid and all m_a_ready SHALL be 0.
REQ-025 Outside RESPONSE, s_d_ready and all m_d_valid SHALL be 0; a spurious s_d_valid SHALL be held off, not dropped.
REQ-026 At most one transaction SHALL be outstanding; the minimum request-to-D-accept time is 3 cycles (grant, A beat, D beat).
REQ-027 A master that loses arbitration SHALL be served no later than NUM_MASTERS-1 transactions later (no starvation).
REQ-028 The request presented to the slave SHALL be independent of m_a_valid changes by non-granted masters.

Reset
REQ-029 While rst=0, the FSM SHALL be IDLE, rr_ptr=0, grant_idx=0, txn_count=0, busy=0, s_a_valid=0, s_d_ready=0, and all m_a_ready and m_d_valid =0.
REQ-030 Reset asserted mid-REQUEST or mid-RESPONSE SHALL abandon the transaction immediately; the block SHALL issue no D beat to any master after rst deasserts.

Structure
REQ-031 Opcode localparams (PUT_FULL_DATA_A=0, PUT_PARTIAL_DATA_A=1, GET_A=4, ACCESS_ACK_D=0, ACCESS_ACK_DATA_D=1), FSM encodings, and default widths SHALL live in the shared package tl_ul_pkg.
REQ-032 Round-robin selection SHALL be one combinational sub-module, tl_ul_rr_picker (inputs req vector and rr_ptr; outputs any and idx).

Verification
REQ-033 Single master: m0 issues Get, addr 0x40, source 1, slave returns AccessAckData 0xDEADBEEF -> only m_d_valid[0] pulses, data 0xDEADBEEF, txn_count=1.
REQ-034 Simultaneous: m0 and m1 both valid from reset -> grant order m0, m1, m0, m1 over 4 transactions; txn_count=4.
REQ-035 Backpressure: s_a_ready=0 for 5 cycles in REQUEST -> s_a fields stable, m_a_ready[1]=0 throughout, A beat accepted on cycle 6.
REQ-036 Spurious D: s_d_valid=1 while IDLE -> s_d_ready=0 and no m_d_valid until a grant reaches RESPONSE.
REQ-037 Reset mid-RESPONSE: drop rst for 1 cycle -> all outputs return to reset values, rr_ptr=0, and m0 wins the next contention.
REQ-038 Wrap: preload txn_count to 16'hFFFF via force, complete 1 transaction -> txn_count=0.
